// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// slave is the decode stage's view; master is the environment's.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic            out_rd_we;
  logic [XLEN-1:0] out_imm;
  logic [10:0]     out_op;
  logic            out_alu_src_imm;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc,
    input  out_rs1, out_rs2, out_rd,
    input  out_rs1_used, out_rs2_used, out_rd_we,
    input  out_imm, out_op, out_alu_src_imm,
    input  out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc,
    output out_rs1, out_rs2, out_rd,
    output out_rs1_used, out_rs2_used, out_rd_we,
    output out_imm, out_op, out_alu_src_imm,
    output out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a circular
// FIFO of decoded entries, flushable, with valid/ready on both sides.
module decode_stage #(
  parameter int XLEN          = 32,
  parameter int BUF_DEPTH     = 2,
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  decode_stage_if.slave                bus,
  output logic [$clog2(BUF_DEPTH):0]   occupancy
);
  localparam int OW = $clog2(BUF_DEPTH) + 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
  localparam logic [OW-1:0] FULL = OW'(BUF_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [10:0]     op;
    logic            alu_src_imm;
    logic            illegal;
  } dec_t;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  assign ins = bus.in_instr;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  logic is_r, is_opi, is_load, is_jalr, is_fence, is_sys;
  logic is_store, is_br, is_lui, is_auipc, is_jal;
  logic is_i, is_u, known;
  assign is_r     = opc == 7'b0110011;
  assign is_opi   = opc == 7'b0010011;
  assign is_load  = opc == 7'b0000011;
  assign is_jalr  = opc == 7'b1100111;
  assign is_fence = opc == 7'b0001111;
  assign is_sys   = opc == 7'b1110011;
  assign is_store = opc == 7'b0100011;
  assign is_br    = opc == 7'b1100011;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_i  = is_opi | is_load | is_jalr | is_fence | is_sys;
  assign is_u  = is_lui | is_auipc;
  assign known = is_i | is_u | is_r | is_store | is_br | is_jal;

  logic [31:0] imm32;
  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      is_i:     imm32 = {{20{ins[31]}}, ins[31:20]};
      is_store: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      is_br:    imm32 = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
      is_u:     imm32 = {ins[31:12], 12'b0};
      is_jal:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
      default:  imm32 = '0;
    endcase
  end

  // funct7 rule shared by R-type and shift-immediates
  logic f7_ok, shift_imm, sys_ok, ill_raw, illegal;
  assign f7_ok = (f7 == 7'h00) ||
                 (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
  assign shift_imm = is_opi && (f3 == 3'b001 || f3 == 3'b101);
  assign sys_ok = (ins == 32'h0000_0073) || (ins == 32'h0010_0073);
  assign ill_raw = (ins[1:0] != 2'b11) || !known
    || (is_br && (f3 == 3'b010 || f3 == 3'b011))
    || (is_load && (f3 == 3'b011 || f3[2:1] == 2'b11))
    || (is_store && f3 > 3'b010)
    || (is_jalr && f3 != 3'b000)
    || (is_r && !f7_ok)
    || (shift_imm && !f7_ok)
    || (is_sys && !sys_ok);
  assign illegal = (CHECK_ILLEGAL != 0) && ill_raw;

  dec_t dec;
  always_comb begin
    dec = '0;
    dec.pc       = bus.in_pc;
    dec.rs1      = ins[19:15];
    dec.rs2      = ins[24:20];
    dec.rd       = ins[11:7];
    dec.rs1_used = is_r | is_opi | is_load | is_jalr
                 | is_store | is_br;
    dec.rs2_used = is_r | is_store | is_br;
    dec.rd_we    = (is_r | is_opi | is_load | is_jalr | is_u | is_jal)
                 && (ins[11:7] != 5'd0) && !illegal;
    dec.imm      = XLEN'($signed(imm32));
    dec.op       = {(is_r | (is_opi && f3 == 3'b101)) & ins[30],
                    f3, opc};
    dec.alu_src_imm = is_i | is_store | is_u | is_jal;
    dec.illegal  = illegal;
  end

  dec_t            mem [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   occ;
  logic            push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign bus.in_ready  = occ < FULL;
  assign bus.out_valid = occ != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= dec;
  end

  // data fields read zero whenever the buffer is empty
  dec_t head;
  assign head = bus.out_valid ? mem[rd_ptr] : '0;

  assign bus.out_pc          = head.pc;
  assign bus.out_rs1         = head.rs1;
  assign bus.out_rs2         = head.rs2;
  assign bus.out_rd          = head.rd;
  assign bus.out_rs1_used    = head.rs1_used;
  assign bus.out_rs2_used    = head.rs2_used;
  assign bus.out_rd_we       = head.rd_we;
  assign bus.out_imm         = head.imm;
  assign bus.out_op          = head.op;
  assign bus.out_alu_src_imm = head.alu_src_imm;
  assign bus.out_illegal     = head.illegal;
  assign occupancy           = occ;
endmodule
